// File: rtl/wb_arbiter.sv
// Purpose: merges the ALU result stream and buffered MDU results onto the single register-file write port.
// Latency: ALU result is written 1 cycle after acceptance; an MDU result is written 2 or more cycles after its push (no bypass).
// Backpressure: Mdu_Ready drops when the FIFO is full; Alu_Ready drops for one cycle once the FIFO head has waited STARVE_MAX cycles.
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     Alu_Valid,
    output logic                     Alu_Ready,
    input  logic [4:0]               Alu_Rd,
    input  logic [XLEN-1:0]          Alu_Data,
    input  logic                     Mdu_Valid,
    output logic                     Mdu_Ready,
    input  logic [4:0]               Mdu_Rd,
    input  logic [XLEN-1:0]          Mdu_Data,
    output logic [$clog2(DEPTH):0]   Mdu_Pend,
    output logic                     Reg_Wr,
    output logic [4:0]               Rd_Wr,
    output logic [XLEN-1:0]          Rd_In
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [WW-1:0] WMAX = WW'(STARVE_MAX);

    // FIFO state
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [4:0]      rd_mem  [DEPTH];
    logic [XLEN-1:0] dat_mem [DEPTH];

    // Cycles the current FIFO head has been passed over in favour of the ALU
    logic [WW-1:0]   wait_cnt;

    logic alu_win;
    logic pop;
    logic push;
    logic fifo_nonempty;

    // Handshakes come from registered state only, so they never depend on this cycle's valids.
    assign Mdu_Ready     = (count != FULL);
    assign Alu_Ready     = (wait_cnt != WMAX);
    assign fifo_nonempty = (count != '0);
    assign Mdu_Pend      = count;

    // Selection: ALU first, then the FIFO head; a full FIFO never pushes even if it pops this cycle.
    assign alu_win = Alu_Valid && Alu_Ready;
    assign pop     = !alu_win && fifo_nonempty;
    assign push    = Mdu_Valid && Mdu_Ready;

    // FIFO storage: payload needs no reset, validity is carried by count.
    always_ff @(posedge CLK) begin
        if (push) begin
            rd_mem[wr_ptr]  <= Mdu_Rd;
            dat_mem[wr_ptr] <= Mdu_Data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Starvation counter: restarts whenever the head moves or nothing is waiting, saturates otherwise.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!fifo_nonempty || pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WMAX) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Write-port register: rd=0 results are consumed without raising the write enable.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            Reg_Wr <= 1'b0;
            Rd_Wr  <= '0;
            Rd_In  <= '0;
        end else if (alu_win) begin
            Reg_Wr <= (Alu_Rd != 5'd0);
            Rd_Wr  <= Alu_Rd;
            Rd_In  <= Alu_Data;
        end else if (pop) begin
            Reg_Wr <= (rd_mem[rd_ptr] != 5'd0);
            Rd_Wr  <= rd_mem[rd_ptr];
            Rd_In  <= dat_mem[rd_ptr];
        end else begin
            Reg_Wr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Purpose: self-checking bench for wb_arbiter with a queue-based reference model and directed vectors.
// Latency: inputs change 2 time units after each rising edge; outputs are compared on the falling edge.
// Backpressure: the ALU stream holds its value while the model reports it was not accepted.
module tb_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic              CLK = 1'b0;
    logic              rst_n = 1'b0;
    logic              Alu_Valid = 1'b0;
    logic              Alu_Ready;
    logic [4:0]        Alu_Rd = '0;
    logic [XLEN-1:0]   Alu_Data = '0;
    logic              Mdu_Valid = 1'b0;
    logic              Mdu_Ready;
    logic [4:0]        Mdu_Rd = '0;
    logic [XLEN-1:0]   Mdu_Data = '0;
    logic [1:0]        Mdu_Pend;
    logic              Reg_Wr;
    logic [4:0]        Rd_Wr;
    logic [XLEN-1:0]   Rd_In;

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .Alu_Valid (Alu_Valid),
        .Alu_Ready (Alu_Ready),
        .Alu_Rd    (Alu_Rd),
        .Alu_Data  (Alu_Data),
        .Mdu_Valid (Mdu_Valid),
        .Mdu_Ready (Mdu_Ready),
        .Mdu_Rd    (Mdu_Rd),
        .Mdu_Data  (Mdu_Data),
        .Mdu_Pend  (Mdu_Pend),
        .Reg_Wr    (Reg_Wr),
        .Rd_Wr     (Rd_Wr),
        .Rd_In     (Rd_In)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending MDU results and the age of its head.
    logic [36:0] m_q[$];
    int          m_age;
    bit          m_alu_acc;
    logic        m_wr;
    logic [4:0]  m_rd;
    logic [31:0] m_dat;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_age     = 0;
            m_alu_acc = 1'b0;
            m_wr      = 1'b0;
            m_rd      = '0;
            m_dat     = '0;
        end else begin
            int sz;
            bit pop_now;
            bit push_now;
            sz        = m_q.size();
            m_alu_acc = Alu_Valid && (m_age < SMAX);
            pop_now   = !m_alu_acc && (sz > 0);
            push_now  = Mdu_Valid && (sz < DEPTH);
            if (m_alu_acc) begin
                m_wr  = (Alu_Rd != 5'd0);
                m_rd  = Alu_Rd;
                m_dat = Alu_Data;
            end else if (pop_now) begin
                m_rd  = m_q[0][36:32];
                m_dat = m_q[0][31:0];
                m_wr  = (m_rd != 5'd0);
                void'(m_q.pop_front());
            end else begin
                m_wr = 1'b0;
            end
            if (sz == 0 || pop_now) m_age = 0;
            else if (m_age < SMAX) m_age++;
            if (push_now) m_q.push_back({Mdu_Rd, Mdu_Data});
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("reg_wr",    64'(Reg_Wr),    64'(m_wr));
            check("rd_wr",     64'(Rd_Wr),     64'(m_rd));
            check("rd_in",     64'(Rd_In),     64'(m_dat));
            check("mdu_pend",  64'(Mdu_Pend),  64'(m_q.size()));
            check("alu_ready", 64'(Alu_Ready), 64'(m_age < SMAX));
            check("mdu_ready", 64'(Mdu_Ready), 64'(m_q.size() != DEPTH));
        end
    end

    task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] mdat);
        @(posedge CLK);
        #2;
        Alu_Valid = av;
        Alu_Rd    = ard;
        Alu_Data  = adat;
        Mdu_Valid = mv;
        Mdu_Rd    = mrd;
        Mdu_Data  = mdat;
    endtask

    int alu_n = 4;

    // Continuous ALU traffic: advance to a new result only once the previous one was accepted.
    task automatic stream(input bit mv, input logic [4:0] mrd, input logic [31:0] mdat);
        @(posedge CLK);
        #2;
        if (Alu_Valid && m_alu_acc) alu_n++;
        Alu_Valid = 1'b1;
        Alu_Rd    = 5'(1 + alu_n % 31);
        Alu_Data  = 32'hA000_0000 + 32'(alu_n);
        Mdu_Valid = mv;
        Mdu_Rd    = mrd;
        Mdu_Data  = mdat;
    endtask

    logic [36:0] sb[$];
    logic [4:0]  held_rd;
    logic [4:0]  r_rd;
    logic [31:0] r_dat;

    initial begin
        // Reset state
        @(posedge CLK);
        #2;
        check("rst_reg_wr",    64'(Reg_Wr),    64'd0);
        check("rst_pend",      64'(Mdu_Pend),  64'd0);
        check("rst_alu_ready", 64'(Alu_Ready), 64'd1);
        check("rst_mdu_ready", 64'(Mdu_Ready), 64'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // ALU path: one result, written next cycle, single-cycle pulse
        drive(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("alu_wr",   64'(Reg_Wr), 64'd1);
        check("alu_rd",   64'(Rd_Wr),  64'd5);
        check("alu_data", 64'(Rd_In),  64'hDEAD_BEEF);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("alu_pulse_end", 64'(Reg_Wr), 64'd0);
        check("alu_rd_hold",   64'(Rd_Wr),  64'd5);

        // MDU path: two consecutive pushes with the ALU idle
        drive(0, 5'd0, 32'd0, 1, 5'd7, 32'h1234_5678);
        check("mdu_pend0", 64'(Mdu_Pend), 64'd0);
        drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h0000_ABCD);
        check("mdu_pend1", 64'(Mdu_Pend), 64'd1);
        check("mdu_nowr",  64'(Reg_Wr),   64'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("mdu_pend2", 64'(Mdu_Pend), 64'd1);
        check("mdu7_wr",   64'(Reg_Wr),   64'd1);
        check("mdu7_rd",   64'(Rd_Wr),    64'd7);
        check("mdu7_data", 64'(Rd_In),    64'h1234_5678);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("mdu_pend3", 64'(Mdu_Pend), 64'd0);
        check("mdu9_wr",   64'(Reg_Wr),   64'd1);
        check("mdu9_rd",   64'(Rd_Wr),    64'd9);
        check("mdu9_data", 64'(Rd_In),    64'h0000_ABCD);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("mdu_idle_wr", 64'(Reg_Wr), 64'd0);

        // Fill under continuous ALU traffic, then reset mid-stream
        stream(1, 5'd11, 32'h1111_0000);
        stream(1, 5'd12, 32'h2222_0000);
        stream(0, 5'd0, 32'd0);
        check("fill_mdu_ready", 64'(Mdu_Ready), 64'd0);
        check("fill_pend",      64'(Mdu_Pend),  64'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_reg_wr",    64'(Reg_Wr),    64'd0);
        check("arst_rd_wr",     64'(Rd_Wr),     64'd0);
        check("arst_rd_in",     64'(Rd_In),     64'd0);
        check("arst_pend",      64'(Mdu_Pend),  64'd0);
        check("arst_mdu_ready", 64'(Mdu_Ready), 64'd1);
        check("arst_alu_ready", 64'(Alu_Ready), 64'd1);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        rst_n = 1'b1;
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // Starvation: one MDU push under continuous ALU traffic
        stream(1, 5'd3, 32'h0000_0333);
        held_rd = '0;
        for (int j = 1; j <= 8; j++) begin
            stream(0, 5'd0, 32'd0);
            check($sformatf("starve_alu_ready_%0d", j), 64'(Alu_Ready), 64'((j == 5) ? 0 : 1));
            if (j == 5) held_rd = Alu_Rd;
            if (j == 6) begin
                check("starve_mdu_wr",   64'(Reg_Wr), 64'd1);
                check("starve_mdu_rd",   64'(Rd_Wr),  64'd3);
                check("starve_mdu_data", 64'(Rd_In),  64'h333);
            end
            if (j == 7) begin
                check("starve_held_wr", 64'(Reg_Wr), 64'd1);
                check("starve_held_rd", 64'(Rd_Wr),  64'(held_rd));
            end
        end
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // x0 suppression on both paths
        drive(1, 5'd0, 32'h55, 0, 5'd0, 32'd0);
        drive(0, 5'd0, 32'd0, 1, 5'd0, 32'h66);
        check("x0_alu_wr", 64'(Reg_Wr), 64'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("x0_pend1", 64'(Mdu_Pend), 64'd1);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("x0_pend0",  64'(Mdu_Pend), 64'd0);
        check("x0_mdu_wr", 64'(Reg_Wr),   64'd0);

        // Simultaneous push/pop at count=1 with a push-order scoreboard
        for (int i = 0; i < 8; i++) begin
            r_rd  = 5'($urandom_range(1, 31));
            r_dat = $urandom;
            drive(0, 5'd0, 32'd0, 1, r_rd, r_dat);
            sb.push_back({r_rd, r_dat});
            if (i >= 1) check($sformatf("pp_pend_%0d", i), 64'(Mdu_Pend), 64'd1);
            if (i >= 2) begin
                check($sformatf("pp_order_%0d", i), 64'({Reg_Wr, Rd_Wr, Rd_In}), 64'({1'b1, sb[0]}));
                void'(sb.pop_front());
            end
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            check($sformatf("pp_drain_%0d", k), 64'({Reg_Wr, Rd_Wr, Rd_In}), 64'({1'b1, sb[0]}));
            void'(sb.pop_front());
        end
        check("pp_final_pend", 64'(Mdu_Pend), 64'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the integer core. It merges the single-cycle ALU/load result stream with results from the long-latency multiply/divide unit (MDU) onto the single write port of the integer register file (`Reg_Wr`, `Rd_Wr`, `Rd_In`). MDU results are buffered in a small FIFO. A starvation counter guarantees the MDU FIFO drains even under continuous ALU traffic.

## Interface
- `XLEN`, 32: data width.
- `DEPTH`, 2: MDU result FIFO depth; power of two, ≥2.
- `STARVE_MAX`, 4: cycles a non-empty FIFO head may wait before the ALU path is back-pressured; ≥1.

Ports:
- `CLK`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Alu_Valid`  in  1  ALU-path result present this cycle.
- `Alu_Ready`  out  1  ALU-path result accepted this cycle.
- `Alu_Rd`  in  5  ALU-path destination register.
- `Alu_Data`  in  XLEN  ALU-path result.
- `Mdu_Valid`  in  1  MDU result present.
- `Mdu_Ready`  out  1  FIFO can accept an MDU result.
- `Mdu_Rd`  in  5  MDU destination register.
- `Mdu_Data`  in  XLEN  MDU result.
- `Mdu_Pend`  out  $clog2(DEPTH)+1  number of MDU results buffered, not yet written.
- `Reg_Wr`  out  1  register-file write enable (registered).
- `Rd_Wr`  out  5  register-file write address (registered).
- `Rd_In`  out  XLEN  register-file write data (registered).

## Operation
- **FIFO**
  - Circular buffer with read pointer, write pointer and count.
  - `Mdu_Ready = (count != DEPTH)`, driven combinationally from the registered count only.
  - Push when `Mdu_Valid && Mdu_Ready`.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- **Starvation counter** `wait_cnt`, range 0..STARVE_MAX:
  - Cleared when the FIFO is empty or when a pop occurs.
  - Otherwise increments and saturates at STARVE_MAX.
- **ALU back-pressure:** `Alu_Ready = (wait_cnt != STARVE_MAX)`, combinational from the register.
- **Per-cycle selection:**
  - ALU wins if `Alu_Valid && Alu_Ready`.
  - Else pop the FIFO head if count is nonzero.
  - Else idle.
- **Output register load:**
  - ALU win: `Rd_Wr ← Alu_Rd`, `Rd_In ← Alu_Data`, `Reg_Wr ← (Alu_Rd != 0)`.
  - Pop: `Rd_Wr ← head rd`, `Rd_In ← head data`, `Reg_Wr ← (head rd != 0)`.
  - Idle: `Reg_Wr ← 0`; `Rd_Wr` and `Rd_In` hold their values.
- **x0 results:** a result with rd=0 is consumed (accepted or popped) but never produces `Reg_Wr=1`.
- **Pending count:** `Mdu_Pend = count`, registered.
- **Simultaneous push and pop** (count < DEPTH): count is unchanged and both pointers advance.

## Timing
- **Reset (async, immediate):**
  - Outputs: `Reg_Wr=0`, `Rd_Wr=0`, `Rd_In=0`, `Mdu_Pend=0`.
  - Internal state: FIFO empty, both pointers 0, `wait_cnt=0`.
  - Handshakes: `Mdu_Ready=1`, `Alu_Ready=1`.
  - Reset mid-operation discards all buffered MDU results; the write in flight is dropped.
- **Latency:**
  - ALU result accepted at edge N: visible on `Reg_Wr/Rd_Wr/Rd_In` after edge N, i.e. 1 cycle.
  - MDU result pushed at edge N: earliest visibility after edge N+1 (2 cycles). There is no FIFO bypass.
- **Write pulse:** `Reg_Wr` is high for exactly one cycle per written result.
- **Upstream holding rules:**
  - ALU source holds `Alu_Valid/Alu_Rd/Alu_Data` stable while `Alu_Ready=0`.
  - MDU source holds its signals while `Mdu_Ready=0`.
- **Worst-case MDU head wait:** STARVE_MAX+1 cycles under continuous `Alu_Valid`.
  - After reaching saturation, `Alu_Ready=0` for exactly one cycle, in which the head pops.
  - The counter then clears.
- **Ordering:**
  - MDU results are written in push order.
  - ALU results are written in acceptance order.
  - No ordering is guaranteed between the two streams; the hazard unit uses `Mdu_Pend`.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with 2 MDU entries buffered → all outputs 0, `Mdu_Pend=0`, `Mdu_Ready=1`, `Alu_Ready=1` immediately, without waiting for a clock edge.
- **ALU path:** `Alu_Valid=1`, `Alu_Rd=5`, `Alu_Data=0xDEADBEEF` for one cycle → next cycle `Reg_Wr=1`, `Rd_Wr=5`, `Rd_In=0xDEADBEEF`; the following cycle `Reg_Wr=0`.
- **MDU path and fill:**
  - Stimulus: ALU idle; push MDU rd=7/0x12345678, then rd=9/0x0000ABCD on consecutive cycles.
  - Writes: rd 7 appears 2 cycles after its push, rd 9 one cycle later.
  - `Mdu_Pend` sequence: 0,1,1,0.
  - With the ALU continuously valid instead, pushing DEPTH entries → `Mdu_Ready=0` after the 2nd push.
- **Starvation** (STARVE_MAX=4):
  - Stimulus: continuous `Alu_Valid` with distinct rd values; one MDU push rd=3.
  - `Alu_Ready` drops for exactly one cycle, 4 cycles after the push.
  - The rd=3 write appears on the cycle after that drop.
  - The held ALU result is written on the next cycle; no ALU result is lost or duplicated.
- **x0 suppression:** ALU rd=0 and MDU rd=0 results → consumed (`Mdu_Pend` decrements) and `Reg_Wr` stays 0.
- **Simultaneous push/pop** at count=1 → count stays 1 and data order is preserved over 8 random pushes; compare against a scoreboard.
